// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - N-phase round-robin turn sequencer with health tracking and game-over detection
//
// Purpose: steps through NUM_PHASES turn phases, one per sub-block. A phase
// ends on the rising edge of that sub-block's finished flag. After the last
// phase a multi-cycle round reset is issued to all sub-blocks. Player and
// enemy health are tracked here. A game-over state (win/lose/draw) ends play
// and can be restarted.
//
// Ports:
//   clk                  system clock
//   rst                  synchronous active-high reset
//   finished_in          per-phase level "done" flag from each sub-block
//   player_dmg_valid_in  apply player_dmg_in this cycle
//   player_dmg_in        damage dealt to the player
//   enemy_dmg_valid_in   apply enemy_dmg_in this cycle
//   enemy_dmg_in         damage dealt to the enemy
//   start_in             restart request, only honoured in game over
//   phase_out            one-hot active phase, zero outside RUN
//   phase_idx_out        binary active phase index
//   round_rst_out        reset to sub-blocks during the round reset
//   player_hp_out        current player health
//   enemy_hp_out         current enemy health
//   round_count_out      completed rounds, saturating
//   game_over_out        high in game over
//   winner_out           01 player won, 10 enemy won, 11 draw, 00 none

module game_sequencer #(
  parameter int NUM_PHASES       = 3,
  parameter int HP_WIDTH         = 8,
  parameter int PLAYER_HP_MAX    = 100,
  parameter int ENEMY_HP_MAX     = 100,
  parameter int ROUND_RST_CYCLES = 2,
  parameter int ROUND_WIDTH      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PHASES-1:0]         finished_in,
  input  logic                          player_dmg_valid_in,
  input  logic [HP_WIDTH-1:0]           player_dmg_in,
  input  logic                          enemy_dmg_valid_in,
  input  logic [HP_WIDTH-1:0]           enemy_dmg_in,
  input  logic                          start_in,
  output logic [NUM_PHASES-1:0]         phase_out,
  output logic [$clog2(NUM_PHASES)-1:0] phase_idx_out,
  output logic                          round_rst_out,
  output logic [HP_WIDTH-1:0]           player_hp_out,
  output logic [HP_WIDTH-1:0]           enemy_hp_out,
  output logic [ROUND_WIDTH-1:0]        round_count_out,
  output logic                          game_over_out,
  output logic [1:0]                    winner_out
);

  localparam int IDX_W = $clog2(NUM_PHASES);
  localparam int CNT_W = $clog2(ROUND_RST_CYCLES + 1);

  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_PHASES - 1);
  localparam logic [CNT_W-1:0]      RST_CNT   = CNT_W'(ROUND_RST_CYCLES);
  localparam logic [HP_WIDTH-1:0]   P_HP_MAX  = HP_WIDTH'(PLAYER_HP_MAX);
  localparam logic [HP_WIDTH-1:0]   E_HP_MAX  = HP_WIDTH'(ENEMY_HP_MAX);
  localparam logic [NUM_PHASES-1:0] PHASE_ONE = NUM_PHASES'(1);

  typedef enum logic [1:0] {
    S_RUN,
    S_ROUND_RST,
    S_GAME_OVER
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_PHASES-1:0]   prev_fin_q;
  logic [NUM_PHASES-1:0]   rise;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_PHASES-1:0]   phase_q, phase_d;
  logic                    rrst_q, rrst_d;
  logic [HP_WIDTH-1:0]     php_q, php_d, php_hit;
  logic [HP_WIDTH-1:0]     ehp_q, ehp_d, ehp_hit;
  logic [ROUND_WIDTH-1:0]  round_q, round_d;
  logic                    go_q, go_d;
  logic [1:0]              win_q, win_d;

  // prev_fin_q tracks finished_in in every state, so a flag that is already
  // high when a phase becomes active never counts as a fresh completion.
  assign rise = finished_in & ~prev_fin_q;

  // Health after this cycle's damage; damage at or above the remaining
  // health clamps to zero instead of wrapping.
  always_comb begin
    php_hit = php_q;
    ehp_hit = ehp_q;
    if (player_dmg_valid_in) begin
      php_hit = (player_dmg_in >= php_q) ? '0 : php_q - player_dmg_in;
    end
    if (enemy_dmg_valid_in) begin
      ehp_hit = (enemy_dmg_in >= ehp_q) ? '0 : ehp_q - enemy_dmg_in;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    rrst_d  = rrst_q;
    php_d   = php_q;
    ehp_d   = ehp_q;
    round_d = round_q;
    go_d    = go_q;
    win_d   = win_q;

    case (state_q)
      S_RUN, S_ROUND_RST: begin
        php_d = php_hit;
        ehp_d = ehp_hit;
        // A fatal hit wins over any phase advance or round end this cycle.
        if (php_hit == '0 || ehp_hit == '0) begin
          state_d = S_GAME_OVER;
          go_d    = 1'b1;
          phase_d = '0;
          rrst_d  = 1'b0;
          win_d   = {php_hit == '0, ehp_hit == '0};
        end else if (state_q == S_RUN) begin
          if (rise[idx_q]) begin
            if (idx_q == LAST_IDX) begin
              state_d = S_ROUND_RST;
              cnt_d   = RST_CNT;
              rrst_d  = 1'b1;
              idx_d   = '0;
              phase_d = '0;
              if (round_q != '1) begin
                round_d = round_q + ROUND_WIDTH'(1);
              end
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              phase_d = PHASE_ONE << idx_d;
            end
          end
        end else begin
          // cnt_q counts the round-reset cycles still to be shown, including this one.
          if (cnt_q <= CNT_W'(1)) begin
            state_d = S_RUN;
            rrst_d  = 1'b0;
            idx_d   = '0;
            phase_d = PHASE_ONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      S_GAME_OVER: begin
        if (start_in) begin
          state_d = S_ROUND_RST;
          cnt_d   = RST_CNT;
          rrst_d  = 1'b1;
          idx_d   = '0;
          phase_d = '0;
          php_d   = P_HP_MAX;
          ehp_d   = E_HP_MAX;
          round_d = '0;
          go_d    = 1'b0;
          win_d   = 2'b00;
        end
      end

      default: begin
        state_d = S_ROUND_RST;
        cnt_d   = RST_CNT;
        rrst_d  = 1'b1;
        idx_d   = '0;
        phase_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_ROUND_RST;
      cnt_q      <= RST_CNT;
      prev_fin_q <= '0;
      idx_q      <= '0;
      phase_q    <= '0;
      rrst_q     <= 1'b1;
      php_q      <= P_HP_MAX;
      ehp_q      <= E_HP_MAX;
      round_q    <= '0;
      go_q       <= 1'b0;
      win_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_fin_q <= finished_in;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      rrst_q     <= rrst_d;
      php_q      <= php_d;
      ehp_q      <= ehp_d;
      round_q    <= round_d;
      go_q       <= go_d;
      win_q      <= win_d;
    end
  end

  assign phase_out       = phase_q;
  assign phase_idx_out   = idx_q;
  assign round_rst_out   = rrst_q;
  assign player_hp_out   = php_q;
  assign enemy_hp_out    = ehp_q;
  assign round_count_out = round_q;
  assign game_over_out   = go_q;
  assign winner_out      = win_q;

endmodule
